// File: rtl/mix_agc_level.sv
// Peak-detecting AGC loop: measures |sample| over a window and steps a gain code.
// Optional MIX_AGC_CONFIRM_EN: a step needs two consecutive windows agreeing on direction.
module mix_agc_level #(
    parameter int unsigned SAMPLE_WIDTH  = 8,
    parameter int unsigned CODE_WIDTH    = 3,
    parameter int unsigned WINDOW_LOG2   = 6,
    parameter int unsigned HI_THRESH     = 96,
    parameter int unsigned LO_THRESH     = 32,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned RESET_CODE    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           agc_enable,
    input  logic [CODE_WIDTH-1:0]          manual_code,
    output logic [CODE_WIDTH-1:0]          agc_code,
    output logic                           code_update,
    output logic [SAMPLE_WIDTH-2:0]        peak_out
);

    localparam int unsigned MagW = SAMPLE_WIDTH - 1;
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CODE_WIDTH-1:0]  CodeMax    = {CODE_WIDTH{1'b1}};
    localparam logic [CODE_WIDTH-1:0]  CodeOne    = CODE_WIDTH'(1);
    localparam logic [CODE_WIDTH-1:0]  CodeRst    = CODE_WIDTH'(RESET_CODE);
    localparam logic [WINDOW_LOG2-1:0] WinOne     = WINDOW_LOG2'(1);
    localparam logic [SetW-1:0]        SetOne     = SetW'(1);
    localparam logic [SetW-1:0]        SettleLast = SetW'(SETTLE_CYCLES - 1);
    localparam logic [MagW-1:0]        HiTh       = MagW'(HI_THRESH);
    localparam logic [MagW-1:0]        LoTh       = MagW'(LO_THRESH);

    typedef enum logic [1:0] {StMeasure, StDecide, StSettle} state_e;

    state_e                  state_q, state_d;
    logic [WINDOW_LOG2-1:0]  win_q, win_d;
    logic [SetW-1:0]         settle_q, settle_d;
    logic [MagW-1:0]         peak_q, peak_d;
    logic [MagW-1:0]         peak_out_q, peak_out_d;
    logic [CODE_WIDTH-1:0]   code_q, code_d;
    logic                    update_q, update_d;

    logic [SAMPLE_WIDTH-1:0] neg_s;
    logic [MagW-1:0]         mag;
    logic                    want_dn, want_up, go_dn, go_up;

`ifdef MIX_AGC_CONFIRM_EN
    typedef enum logic [1:0] {PendNone, PendUp, PendDn} pend_e;
    pend_e pend_q, pend_d;
`endif

    // Two's-complement negation overflows only for the most negative value.
    always_comb begin
        neg_s = -sample_in;
        if (!sample_in[SAMPLE_WIDTH-1]) begin
            mag = sample_in[MagW-1:0];
        end else if (neg_s[SAMPLE_WIDTH-1]) begin
            mag = '1;
        end else begin
            mag = neg_s[MagW-1:0];
        end
    end

    always_comb begin
        want_dn = (peak_q > HiTh);
        want_up = (peak_q < LoTh);
`ifdef MIX_AGC_CONFIRM_EN
        go_dn = want_dn && (code_q != '0) && (pend_q == PendDn);
        go_up = want_up && (code_q != CodeMax) && (pend_q == PendUp);
`else
        go_dn = want_dn && (code_q != '0);
        go_up = want_up && (code_q != CodeMax);
`endif
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        settle_d   = settle_q;
        peak_d     = peak_q;
        peak_out_d = peak_out_q;
        code_d     = code_q;
`ifdef MIX_AGC_CONFIRM_EN
        pend_d     = pend_q;
`endif
        if (!agc_enable) begin
            state_d  = StMeasure;
            win_d    = '0;
            settle_d = '0;
            peak_d   = '0;
            code_d   = manual_code;
`ifdef MIX_AGC_CONFIRM_EN
            pend_d   = PendNone;
`endif
        end else begin
            unique case (state_q)
                StMeasure: begin
                    if (sample_valid) begin
                        if (mag > peak_q) peak_d = mag;
                        win_d = win_q + WinOne;
                        if (win_q == '1) state_d = StDecide;
                    end
                end
                StDecide: begin
                    peak_out_d = peak_q;
                    peak_d     = '0;
                    win_d      = '0;
                    if (go_dn) begin
                        code_d = code_q - CodeOne;
                    end else if (go_up) begin
                        code_d = code_q + CodeOne;
                    end
                    state_d = (go_dn || go_up) ? StSettle : StMeasure;
`ifdef MIX_AGC_CONFIRM_EN
                    if (go_dn || go_up) pend_d = PendNone;
                    else if (want_dn)   pend_d = PendDn;
                    else if (want_up)   pend_d = PendUp;
                    else                pend_d = PendNone;
`endif
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        settle_d = '0;
                        state_d  = StMeasure;
                    end else begin
                        settle_d = settle_q + SetOne;
                    end
                end
                default: state_d = StMeasure;
            endcase
        end
        update_d = (code_d != code_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StMeasure;
            win_q      <= '0;
            settle_q   <= '0;
            peak_q     <= '0;
            peak_out_q <= '0;
            code_q     <= CodeRst;
            update_q   <= 1'b0;
`ifdef MIX_AGC_CONFIRM_EN
            pend_q     <= PendNone;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            settle_q   <= settle_d;
            peak_q     <= peak_d;
            peak_out_q <= peak_out_d;
            code_q     <= code_d;
            update_q   <= update_d;
`ifdef MIX_AGC_CONFIRM_EN
            pend_q     <= pend_d;
`endif
        end
    end

    assign agc_code    = code_q;
    assign code_update = update_q;
    assign peak_out    = peak_out_q;

endmodule
